step_scheduler: RTL

Sequences the 16-voice oscillator bank.
- Derives a 100 Hz tick from the 50 MHz system clock.
- Holds each step for a user-set number of ticks.
- Drives a one-hot note-on/off trigger to the per-voice ADSRs.
- Pulses end_count when the 16-step pass wraps.

It sits between the Arduino tempo input and the voice memory/ADSR bank, and replaces free-running counters with one shared scheduler.

---
 rtl/step_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/step_scheduler.sv
// step_scheduler: tick prescaler, tempo latch and 16-step one-hot gate sequencer.
module step_scheduler #(
  parameter int unsigned BASE_DIV  = 500000,
  parameter int unsigned TEMPO_RST = 100,
  parameter int unsigned STEPS     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  user_input,
  input  logic [1:0]  ctrl,
  input  logic        run,
  output logic [15:0] trigger_adsr,
  output logic [3:0]  step_idx,
  output logic        step_pulse,
  output logic        end_count,
  output logic        tick_100hz
);

  localparam int unsigned PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_ON  = 2'd1,
    GATE_OFF = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]  tick_count_q, tick_count_d;
  logic [9:0]  tempo_pend_q, tempo_pend_d;
  logic [9:0]  tempo_act_q, tempo_act_d;
  logic [11:0] gate_q, gate_d;
  logic [3:0]  step_idx_q, step_idx_d;
  logic [15:0] trigger_q, trigger_d;
  logic        step_pulse_q, step_pulse_d;
  logic        end_count_q, end_count_d;

  logic        tick;
  logic [2:0]  gate_k;
  logic [11:0] gate_prod;
  logic [11:0] gate_new;
  logic [10:0] tc_inc;
  logic [3:0]  next_idx;
  logic        step_end;
  logic        gate_end;

  assign tick = (pre_q == PW'(BASE_DIV - 1));

  // Gate length and boundary detection; the boundary test is evaluated
  // first so a coincident gate end never produces a zero cycle.
  always_comb begin
    unique case (ctrl)
      2'b00:   gate_k = 3'd2;
      2'b01:   gate_k = 3'd1;
      2'b10:   gate_k = 3'd3;
      default: gate_k = 3'd4;
    endcase
    gate_prod = ({2'b00, tempo_pend_q} * {9'd0, gate_k}) >> 2;
    gate_new  = (gate_prod == '0) ? 12'd1 : gate_prod;
    tc_inc    = {1'b0, tick_count_q} + 11'd1;
    next_idx  = (step_idx_q == 4'(STEPS - 1)) ? '0 : step_idx_q + 4'd1;
    step_end  = tick && (tc_inc == {1'b0, tempo_act_q});
    gate_end  = tick && ({1'b0, tc_inc} == gate_q) && (gate_q < {2'b00, tempo_act_q});
  end

  always_comb begin
    state_d      = state_q;
    pre_d        = tick ? '0 : pre_q + 1'b1;
    tick_count_d = tick_count_q;
    tempo_pend_d = enable ? ((user_input == '0) ? 10'd1 : user_input) : tempo_pend_q;
    tempo_act_d  = tempo_act_q;
    gate_d       = gate_q;
    step_idx_d   = step_idx_q;
    trigger_d    = trigger_q;
    step_pulse_d = 1'b0;
    end_count_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        trigger_d = '0;
        if (run) begin
          state_d      = GATE_ON;
          pre_d        = '0;
          tick_count_d = '0;
          step_idx_d   = '0;
          trigger_d    = 16'd1;
          step_pulse_d = 1'b1;
          tempo_act_d  = tempo_pend_q;
          gate_d       = gate_new;
        end
      end
      default: begin
        if (step_end) begin
          tick_count_d = '0;
          step_idx_d   = next_idx;
          end_count_d  = (step_idx_q == 4'(STEPS - 1));
          tempo_act_d  = tempo_pend_q;
          gate_d       = gate_new;
          if (run) begin
            state_d      = GATE_ON;
            trigger_d    = 16'd1 << next_idx;
            step_pulse_d = 1'b1;
          end else begin
            state_d   = IDLE;
            trigger_d = '0;
          end
        end else if (tick) begin
          tick_count_d = tc_inc[9:0];
          if (state_q == GATE_ON && gate_end) begin
            state_d   = GATE_OFF;
            trigger_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      tick_count_q <= '0;
      tempo_pend_q <= 10'(TEMPO_RST);
      tempo_act_q  <= 10'(TEMPO_RST);
      gate_q       <= 12'd1;
      step_idx_q   <= '0;
      trigger_q    <= '0;
      step_pulse_q <= 1'b0;
      end_count_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      tick_count_q <= tick_count_d;
      tempo_pend_q <= tempo_pend_d;
      tempo_act_q  <= tempo_act_d;
      gate_q       <= gate_d;
      step_idx_q   <= step_idx_d;
      trigger_q    <= trigger_d;
      step_pulse_q <= step_pulse_d;
      end_count_q  <= end_count_d;
    end
  end

  assign trigger_adsr = trigger_q;
  assign step_idx     = step_idx_q;
  assign step_pulse   = step_pulse_q;
  assign end_count    = end_count_q;
  assign tick_100hz   = tick;

endmodule
